// File: rtl/camera_capture_pkg.sv
// camera_capture_pkg: shared types and constants for the camera capture path
// FSM states, RGB444 field widths, default sensor geometry
package camera_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_VSYNC,
    ST_WAIT_ACTIVE,
    ST_CAPTURE
  } cam_state_t;

  localparam int CH_W  = 4;
  localparam int RGB_W = 3 * CH_W;
  localparam int POS_W = 9;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_DECIMATE = 2;

  function automatic logic on_grid(input int v, input int d);
    return (v % d) == 0;
  endfunction

endpackage

// File: rtl/cam_sync_edge.sv
// cam_sync_edge: two-flop synchronizer with edge detection
// level and edges both come from stage 2 so they line up with synced data
module cam_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  // synchronizer chain plus one history stage for the edge compare
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/camera_capture.sv
// camera_capture: RGB444 camera byte stream to decimated draw-point writes
// camera pins are oversampled by the system clock and treated as data
module camera_capture
  import camera_capture_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int DECIMATE = DEF_DECIMATE
) (
  input  logic             piul1Clock,
  input  logic             piul1Reset,
  input  logic             piul1Enable,
  input  logic             piul1CamPclk,
  input  logic             piul1CamVsync,
  input  logic             piul1CamHref,
  input  logic [7:0]       piul8CamData,
  output logic [POS_W-1:0] poul9PosX,
  output logic [POS_W-1:0] poul9PosY,
  output logic [RGB_W-1:0] poul12Rgb12Data,
  output logic             poul1Update,
  output logic             poul1FrameDone,
  output logic             poul1FrameError
);

  localparam int XW = $clog2(H_ACTIVE + 1);
  localparam int YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0] X_END = XW'(H_ACTIVE);
  localparam logic [YW-1:0] Y_END = YW'(V_ACTIVE);

  logic clk;
  logic rst;
  assign clk = piul1Clock;
  assign rst = piul1Reset;

  logic pclk_level, pclk_rise, pclk_fall;
  logic vs_level, vs_rise, vs_fall;
  logic href_level, href_rise, href_fall;

  cam_sync_edge u_pclk (
    .clk   (clk),
    .rst   (rst),
    .din   (piul1CamPclk),
    .level (pclk_level),
    .rise  (pclk_rise),
    .fall  (pclk_fall)
  );

  cam_sync_edge u_vsync (
    .clk   (clk),
    .rst   (rst),
    .din   (piul1CamVsync),
    .level (vs_level),
    .rise  (vs_rise),
    .fall  (vs_fall)
  );

  cam_sync_edge u_href (
    .clk   (clk),
    .rst   (rst),
    .din   (piul1CamHref),
    .level (href_level),
    .rise  (href_rise),
    .fall  (href_fall)
  );

  logic unused_ok;
  assign unused_ok = ^{pclk_level, pclk_fall, vs_level, href_rise};

  logic [7:0] data_s1;
  logic [7:0] data_s2;

  // data bus synchronizer, same depth as the pclk/href level stage
  always_ff @(posedge clk) begin
    if (rst) begin
      data_s1 <= '0;
      data_s2 <= '0;
    end else begin
      data_s1 <= piul8CamData;
      data_s2 <= data_s1;
    end
  end

  cam_state_t state;
  cam_state_t state_next;

  // capture state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // frame sequencing; enable only matters at frame boundaries
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE:
        if (piul1Enable) state_next = ST_WAIT_VSYNC;
      ST_WAIT_VSYNC:
        if (vs_rise) state_next = ST_WAIT_ACTIVE;
      ST_WAIT_ACTIVE:
        if (vs_fall) state_next = ST_CAPTURE;
      ST_CAPTURE:
        if (vs_rise)
          state_next = piul1Enable ? ST_WAIT_VSYNC : ST_IDLE;
      default:
        state_next = ST_IDLE;
    endcase
  end

  logic [XW-1:0]   x;
  logic [YW-1:0]   y;
  logic            phase;
  logic [CH_W-1:0] red;

  logic capturing;
  logic byte_stb;
  logic pixel_done;
  logic line_end;
  logic frame_end;
  logic frame_start;
  logic err_clear;
  logic pix_ok;
  logic grid_hit;
  logic line_bad;
  logic err_set;

  assign capturing   = (state == ST_CAPTURE);
  assign byte_stb    = capturing & pclk_rise & href_level;
  assign pixel_done  = byte_stb & phase;
  assign line_end    = capturing & href_fall;
  assign frame_end   = capturing & vs_rise;
  assign frame_start = (state == ST_WAIT_ACTIVE) & vs_fall;
  assign err_clear   = (state == ST_WAIT_VSYNC) & vs_rise;
  assign pix_ok      = (x != X_END) && (y != Y_END);
  assign grid_hit    = on_grid(int'(x), DECIMATE)
                     && on_grid(int'(y), DECIMATE);
  assign line_bad    = phase || (x != X_END);
  assign err_set     = (pixel_done && !pix_ok)
                     || (line_end && line_bad)
                     || (frame_end && (y != Y_END));

  // pixel assembly and line/column counters
  always_ff @(posedge clk) begin
    if (rst) begin
      x     <= '0;
      y     <= '0;
      phase <= 1'b0;
      red   <= '0;
    end else if (frame_start) begin
      x     <= '0;
      y     <= '0;
      phase <= 1'b0;
    end else if (line_end) begin
      x     <= '0;
      phase <= 1'b0;
      if (y != Y_END) y <= y + YW'(1);
    end else if (byte_stb) begin
      phase <= ~phase;
      if (!phase) red <= data_s2[CH_W-1:0];
      else if (x != X_END) x <= x + XW'(1);
    end
  end

  // draw-point write port; values hold between strobes
  always_ff @(posedge clk) begin
    if (rst) begin
      poul9PosX       <= '0;
      poul9PosY       <= '0;
      poul12Rgb12Data <= '0;
      poul1Update     <= 1'b0;
    end else begin
      poul1Update <= 1'b0;
      if (pixel_done && pix_ok && grid_hit) begin
        poul9PosX       <= POS_W'(int'(x) / DECIMATE);
        poul9PosY       <= POS_W'(int'(y) / DECIMATE);
        poul12Rgb12Data <= {red, data_s2};
        poul1Update     <= 1'b1;
      end
    end
  end

  // frame-done pulse and sticky error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      poul1FrameDone  <= 1'b0;
      poul1FrameError <= 1'b0;
    end else begin
      poul1FrameDone <= frame_end;
      if (err_clear)    poul1FrameError <= 1'b0;
      else if (err_set) poul1FrameError <= 1'b1;
    end
  end

endmodule

// File: tb/tb_camera_capture.sv
// tb_camera_capture: directed frames on a 16x8 sensor, decimate by 2
// expected writes queued by the stimulus, matched by a monitor
module tb_camera_capture;

  localparam int H = 16;
  localparam int V = 8;
  localparam int D = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        cam_pclk;
  logic        cam_vsync;
  logic        cam_href;
  logic [7:0]  cam_data;
  logic [8:0]  pos_x;
  logic [8:0]  pos_y;
  logic [11:0] rgb;
  logic        update;
  logic        frame_done;
  logic        frame_error;

  always #5 clk = ~clk;

  camera_capture #(
    .H_ACTIVE (H),
    .V_ACTIVE (V),
    .DECIMATE (D)
  ) dut (
    .piul1Clock      (clk),
    .piul1Reset      (rst),
    .piul1Enable     (enable),
    .piul1CamPclk    (cam_pclk),
    .piul1CamVsync   (cam_vsync),
    .piul1CamHref    (cam_href),
    .piul8CamData    (cam_data),
    .poul9PosX       (pos_x),
    .poul9PosY       (pos_y),
    .poul12Rgb12Data (rgb),
    .poul1Update     (update),
    .poul1FrameDone  (frame_done),
    .poul1FrameError (frame_error)
  );

  typedef struct {
    logic [8:0]  px;
    logic [8:0]  py;
    logic [11:0] rgb;
  } exp_t;

  exp_t exp_q[$];

  int total = 0;
  int bad = 0;
  int upd_cnt = 0;
  int done_cnt = 0;
  int last_x = 0;
  int last_y = 0;
  bit cap = 1'b0;
  bit lat_next = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, want);
    end
  endtask

  // monitor: pop one expectation per write strobe, count frame pulses
  always @(negedge clk) begin
    if (frame_done) done_cnt++;
    if (update) begin
      upd_cnt++;
      last_x = int'(pos_x);
      last_y = int'(pos_y);
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_update: got x=%0d y=%0d rgb=%h want none",
                 pos_x, pos_y, rgb);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (pos_x !== e.px || pos_y !== e.py || rgb !== e.rgb) begin
          bad++;
          $display("FAIL write: got x=%0d y=%0d rgb=%h want x=%0d y=%0d rgb=%h",
                   pos_x, pos_y, rgb, e.px, e.py, e.rgb);
        end
      end
    end
  end

  function automatic logic [11:0] pix(input int x, input int y);
    logic [7:0] xb;
    logic [7:0] yb;
    xb = 8'(x);
    yb = 8'(y);
    if (x == 0 && y == 0) return 12'hA5C;
    return {xb[3:0], yb[3:0], xb[7:4]};
  endfunction

  task automatic pclk_byte(input logic [7:0] d, input bit lat);
    cam_data = d;
    cam_pclk = 1'b0;
    repeat (4) @(negedge clk);
    cam_pclk = 1'b1;
    if (lat) begin
      repeat (2) @(posedge clk);
      #1 chk("latency_early", {31'd0, update}, 32'd0);
      @(posedge clk);
      #1 chk("latency_on_time", {31'd0, update}, 32'd1);
      repeat (2) @(negedge clk);
    end else begin
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic send_line(input int y, input int nbytes, input bit drop);
    cam_href = 1'b1;
    for (int b = 0; b < nbytes; b++) begin
      int x;
      logic [11:0] p;
      bit lat;
      x = b / 2;
      p = pix(x, y);
      lat = lat_next && (y == 0) && (b == 1);
      if ((b % 2 == 1) && cap && x < H && y < V && (x % D == 0) && (y % D == 0))
        exp_q.push_back('{9'(x / D), 9'(y / D), p});
      pclk_byte((b % 2 == 0) ? {4'h0, p[11:8]} : p[7:0], lat);
    end
    if (drop) begin
      cam_pclk = 1'b0;
      cam_href = 1'b0;
      repeat (8) @(negedge clk);
    end
  endtask

  task automatic vsync_pulse();
    cam_vsync = 1'b1;
    repeat (8) @(negedge clk);
    cam_vsync = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic run_frame(input int nlines, input int en_off_line);
    for (int y = 0; y < nlines; y++) begin
      if (y == en_off_line) enable = 1'b0;
      send_line(y, 2 * H, 1'b1);
    end
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    cam_pclk = 1'b0;
    cam_vsync = 1'b0;
    cam_href = 1'b0;
    cam_data = 8'h00;
    repeat (3) @(negedge clk);
    chk("rst_posx", 32'(pos_x), 32'd0);
    chk("rst_posy", 32'(pos_y), 32'd0);
    chk("rst_rgb", 32'(rgb), 32'd0);
    chk("rst_update", 32'(update), 32'd0);
    chk("rst_done", 32'(frame_done), 32'd0);
    chk("rst_error", 32'(frame_error), 32'd0);
    rst = 1'b0;
    enable = 1'b1;
    repeat (2) @(negedge clk);

    // good frame, first pixel 0x0A,0x5C with latency probe
    vsync_pulse();
    cap = 1'b1;
    upd_cnt = 0;
    lat_next = 1'b1;
    run_frame(V, -1);
    lat_next = 1'b0;
    vsync_pulse();
    chk("f1_updates", 32'(upd_cnt), 32'd32);
    chk("f1_last_x", 32'(last_x), 32'd7);
    chk("f1_last_y", 32'(last_y), 32'd3);
    chk("f1_done", 32'(done_cnt), 32'd1);
    chk("f1_error", 32'(frame_error), 32'd0);

    // odd byte count on line 1, short line with partial grid pixel on line 2
    vsync_pulse();
    upd_cnt = 0;
    for (int y = 0; y < V; y++) begin
      int nb;
      nb = (y == 1) ? 2 * H - 1 : (y == 2) ? 2 * H - 3 : 2 * H;
      send_line(y, nb, 1'b1);
      if (y == 1) chk("badline_error", 32'(frame_error), 32'd1);
    end
    vsync_pulse();
    chk("f2_updates", 32'(upd_cnt), 32'd31);
    chk("f2_done", 32'(done_cnt), 32'd2);
    chk("f2_error_sticky", 32'(frame_error), 32'd1);

    // short frame: 6 of 8 lines
    vsync_pulse();
    chk("f3_error_cleared", 32'(frame_error), 32'd0);
    upd_cnt = 0;
    run_frame(6, -1);
    vsync_pulse();
    chk("f3_updates", 32'(upd_cnt), 32'd24);
    chk("f3_done", 32'(done_cnt), 32'd3);
    chk("f3_error", 32'(frame_error), 32'd1);

    // good frame clears the error
    vsync_pulse();
    chk("f4_error_cleared", 32'(frame_error), 32'd0);
    upd_cnt = 0;
    run_frame(V, -1);
    vsync_pulse();
    chk("f4_updates", 32'(upd_cnt), 32'd32);
    chk("f4_done", 32'(done_cnt), 32'd4);
    chk("f4_error", 32'(frame_error), 32'd0);

    // enable drops mid-frame; frame still completes, next one ignored
    vsync_pulse();
    upd_cnt = 0;
    run_frame(V, 4);
    vsync_pulse();
    chk("f5_updates", 32'(upd_cnt), 32'd32);
    chk("f5_done", 32'(done_cnt), 32'd5);
    cap = 1'b0;
    upd_cnt = 0;
    vsync_pulse();
    run_frame(V, -1);
    vsync_pulse();
    chk("idle_updates", 32'(upd_cnt), 32'd0);
    chk("idle_done", 32'(done_cnt), 32'd5);

    // reset in the middle of line 4, pixel 6
    enable = 1'b1;
    repeat (2) @(negedge clk);
    vsync_pulse();
    cap = 1'b1;
    upd_cnt = 0;
    for (int y = 0; y < 4; y++) send_line(y, 2 * H, 1'b1);
    send_line(4, 13, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_posx", 32'(pos_x), 32'd0);
    chk("mid_rst_posy", 32'(pos_y), 32'd0);
    chk("mid_rst_rgb", 32'(rgb), 32'd0);
    chk("mid_rst_update", 32'(update), 32'd0);
    chk("mid_rst_error", 32'(frame_error), 32'd0);
    rst = 1'b0;
    cap = 1'b0;
    cam_pclk = 1'b0;
    cam_href = 1'b0;
    repeat (8) @(negedge clk);
    send_line(5, 2 * H, 1'b1);
    send_line(6, 2 * H, 1'b1);
    chk("pre_rst_updates", 32'(upd_cnt), 32'd19);
    vsync_pulse();
    chk("post_rst_done", 32'(done_cnt), 32'd5);
    cap = 1'b1;
    upd_cnt = 0;
    run_frame(V, -1);
    vsync_pulse();
    chk("f6_updates", 32'(upd_cnt), 32'd32);
    chk("f6_done", 32'(done_cnt), 32'd6);
    chk("f6_error", 32'(frame_error), 32'd0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/camera_capture.md
CAMERA_CAPTURE -- requirements
Module: camera_capture

Interface
REQ-001 Parameter H_ACTIVE, default 640, meaning camera active pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, meaning camera active lines per frame.
REQ-003 Parameter DECIMATE, default 2, meaning the integer subsample factor in both axes (output grid 320x240 at defaults).
REQ-004 piul1Clock  in  1  system clock; all logic on its rising edge; camera PCLK frequency SHALL be at most 1/4 of it.
REQ-005 piul1Reset  in  1  reset, synchronous, active-high.
REQ-006 piul1Enable  in  1  capture enable, sampled only at frame boundaries.
REQ-007 piul1CamPclk  in  1  camera pixel clock, asynchronous, treated as data.
REQ-008 piul1CamVsync  in  1  camera frame sync, active-high, asynchronous.
REQ-009 piul1CamHref  in  1  camera line-valid, active-high, asynchronous.
REQ-010 piul8CamData  in  8  camera byte, RGB444 (byte0 = xxxxRRRR, byte1 = GGGGBBBB).
REQ-011 poul9PosX  out  9  output pixel column.
REQ-012 poul9PosY  out  9  output pixel row.
REQ-013 poul12Rgb12Data  out  12  pixel {R,G,B}, 4 bits each.
REQ-014 poul1Update  out  1  one-cycle write strobe qualifying PosX/PosY/Rgb12Data (drives the draw-point write port).
REQ-015 poul1FrameDone  out  1  one-cycle pulse at end of each captured frame.
REQ-016 poul1FrameError  out  1  sticky error flag.

Function
REQ-017 PCLK, VSYNC, HREF and data SHALL pass through a 2-flop synchronizer; a PCLK rising edge is detected from synchronized stages 2 and 3, and HREF/data SHALL be sampled from the same stage as the edge.
REQ-018 FSM states: ST_IDLE, ST_WAIT_VSYNC, ST_WAIT_ACTIVE, ST_CAPTURE.
REQ-019 ST_IDLE -> ST_WAIT_VSYNC when Enable=1; ST_WAIT_VSYNC -> ST_WAIT_ACTIVE on synchronized VSYNC rising edge; ST_WAIT_ACTIVE -> ST_CAPTURE on VSYNC falling edge.
REQ-020 ST_CAPTURE -> ST_WAIT_VSYNC on next VSYNC rising edge if Enable=1, else -> ST_IDLE; FrameDone pulses on that transition.
REQ-021 In ST_CAPTURE, each PCLK edge with HREF=1 toggles a byte-phase bit; phase 0 latches data[3:0] as R, phase 1 completes the pixel and increments column counter X (0..H_ACTIVE-1).
REQ-022 HREF falling edge SHALL reset X and byte phase to 0 and increment line counter Y (0..V_ACTIVE-1); Y resets on VSYNC falling edge.
REQ-023 A completed pixel with X mod DECIMATE = 0 and Y mod DECIMATE = 0 SHALL drive PosX = X/DECIMATE, PosY = Y/DECIMATE, Rgb12Data = {R, byte1}, and Update=1 exactly one clock after the phase-1 sampling edge.
REQ-024 Outputs PosX/PosY/Rgb12Data SHALL hold their value until the next Update.
REQ-025 X reaching H_ACTIVE or Y reaching V_ACTIVE SHALL saturate (no write, no wrap) and set FrameError.
REQ-026 HREF falling with byte phase 1 (odd byte count) or X != H_ACTIVE SHALL set FrameError; the partial pixel is discarded.
REQ-027 VSYNC rising with Y != V_ACTIVE SHALL set FrameError; FrameDone still pulses.
REQ-028 Enable deassertion mid-frame SHALL NOT stop the current frame; capture ends at the next VSYNC rise.
REQ-029 FrameError clears only on reset or on entry to ST_WAIT_ACTIVE from ST_WAIT_VSYNC.

Reset
REQ-030 Reset SHALL force ST_IDLE, X=Y=0, phase=0, synchronizers=0, PosX=PosY=0, Rgb12Data=0, Update=0, FrameDone=0, FrameError=0.
REQ-031 Reset mid-line SHALL discard the partial frame; no Update until the next full VSYNC cycle after Enable.

Structure
REQ-032 FSM state enum, RGB444 field widths and default resolution constants SHALL live in the shared camera package.
REQ-033 The synchronizer plus edge detector SHALL be a sub-module named cam_sync_edge, instantiated once per asynchronous control input.

Verification
REQ-034 Reset then Enable, one 640x480 RGB444 frame with pixel value = {X[3:0],Y[3:0],X[7:4]} -> 76800 Updates, last PosX=319/PosY=239, FrameDone once, FrameError=0.
REQ-035 Bytes 0x0A,0x5C at X=0,Y=0 -> Update with Rgb12Data=12'hA5C, PosX=0, PosY=0, one clock after second PCLK edge.
REQ-036 Line with 1279 bytes -> FrameError=1, no Update for the partial pixel, next line captured normally.
REQ-037 Frame with 470 lines -> FrameError=1 at VSYNC rise, FrameDone pulses; next good frame clears error.
REQ-038 Enable=0 asserted at line 100 -> frame completes, then ST_IDLE, zero Updates in following frame.
REQ-039 Reset asserted at X=300, Y=50 -> all outputs 0 next cycle, no Update until after a full VSYNC pulse.
